dsss_dpsk_demod: RTL
====================

DSSS_DPSK_DEMOD -- requirements
Module: dsss_dpsk_demod

Interface
REQ-001 Parameter IW, default 23: width of the correlator inputs.
REQ-002 Parameter MISS_MAX, default 3: number of consecutive unlocked symbol strobes tolerated before returning to UNLOCK.
REQ-003 clk  in  1: system clock, 49.6 MHz.
REQ-004 rst  in  1: reset, synchronous and active-low.
REQ-005 locked  in  1: PN lock indicator from the PN synchroniser.
REQ-006 bit_sync  in  1: one-cycle symbol strobe; douti and doutq are valid in the same cycle.
REQ-007 douti  in  IW signed: I-branch punctual correlator integral.
REQ-008 doutq  in  IW signed: Q-branch punctual correlator integral.
REQ-009 bit_out  out  1: demodulated differential bit.
REQ-010 bit_valid  out  1: one-cycle qualifier for bit_out.
REQ-011 byte_out  out  8: assembled byte, MSB first.
REQ-012 byte_valid  out  1: one-cycle qualifier for byte_out.
REQ-013 dot_out  out  37 signed: differential dot product of the last decided symbol.
REQ-014 state  out  2: FSM state (00 UNLOCK, 01 FIRST, 10 TRACK).

Function
REQ-015 Only douti[IW-1:IW-18] and doutq[IW-1:IW-18] (18-bit signed) SHALL be used.
REQ-016 The dot product SHALL be Icur*Iprev + Qcur*Qprev, computed at full 37-bit precision with no truncation or saturation.
REQ-017 bit_out SHALL be 1 when dot < 0 (phase reversal) and 0 when dot >= 0.
REQ-018 bit_valid, bit_out and dot_out SHALL update exactly 3 cycles after the accepted bit_sync: capture, multiply, then sum/decide.
REQ-019 The pipeline SHALL accept a bit_sync every 4 or more cycles; a minimum spacing of 4 is guaranteed by the upstream stage.
REQ-020 UNLOCK: all strobes are ignored; the FSM moves to FIRST on the first cycle with locked=1.
REQ-021 FIRST: the next bit_sync with locked=1 SHALL store Iprev/Qprev, produce no bit, and move the FSM to TRACK; locked=0 SHALL return the FSM to UNLOCK.
REQ-022 TRACK, bit_sync with locked=1: produce a bit, update Iprev/Qprev with the current symbol, clear the miss counter.
REQ-023 TRACK, bit_sync with locked=0: discard the symbol, leave prev unchanged, and increment the miss counter.
REQ-024 When the miss counter reaches MISS_MAX, the FSM SHALL move to UNLOCK.
REQ-025 On entry to UNLOCK, the miss counter, bit counter and shift register SHALL be cleared, and in-flight pipeline results SHALL be suppressed (no bit_valid).
REQ-026 Bytes SHALL be assembled by shifting bits in MSB first; byte_valid SHALL assert in the same cycle as the 8th bit_valid, and the bit counter wraps 7 -> 0.
REQ-027 A bit_sync coinciding with a locked falling edge SHALL be evaluated against the locked value in that same cycle.
REQ-028 byte_out and dot_out SHALL hold their values between valid pulses.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL reset to: state=UNLOCK, bit_out=0, bit_valid=0, byte_out=0, byte_valid=0, dot_out=0, Iprev=Qprev=0, counters=0, pipeline valids=0.
REQ-030 Reset asserted mid-symbol SHALL cancel any in-flight result; no valid pulse SHALL appear after release until a new FIRST->TRACK sequence completes.

Structure
REQ-031 The shared package SHALL hold the state encoding, the 18-bit slice width, the 37-bit dot width and the MISS_MAX default.
REQ-032 The multiply-add pipeline (capture excluded) SHALL be the sub-module dpsk_dot: 2 cycles, with a valid pass-through and a synchronous flush input.

Verification
REQ-033 locked=1; symbols (I,Q) = (1000,0),(1000,0),(-1000,0),(-1000,0), all on bits [22:5] -> bits 0,1,0 and dot_out = 1000000, -1000000, 1000000.
REQ-034 TRACK; bit_sync at cycle n -> bit_valid high only at n+3; 4-cycle strobe spacing gives no lost bits.
REQ-035 Symbols encoding 0xA5 after the FIRST symbol -> one byte_valid with byte_out=0xA5, coincident with the 8th bit_valid.
REQ-036 TRACK, locked=0 for 2 strobes then 1 -> FSM stays TRACK, 2 symbols dropped, no bit_valid; locked=0 for 3 strobes -> FSM=UNLOCK, byte counter cleared.
REQ-037 Pulse rst=0 one cycle after a bit_sync in TRACK -> no bit_valid; all outputs zero; state=00.
REQ-038 Extreme values I=Q=-131072 for both cur and prev -> dot_out = +34359738368 with no overflow; bit_out=0.

Source files
------------

// File: rtl/dsss_dpsk_demod_pkg.sv
// Shared types and widths for the DSSS DPSK demodulator.
package dsss_dpsk_demod_pkg;
  localparam int SLICE_W          = 18;
  localparam int DOT_W            = 37;
  localparam int MISS_MAX_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'b00,
    ST_FIRST  = 2'b01,
    ST_TRACK  = 2'b10
  } state_t;
endpackage

// File: rtl/dsss_dpsk_demod_dot.sv
// Two-stage differential dot product: per-branch multiply, then full-width sum.
module dpsk_dot
  import dsss_dpsk_demod_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic signed [SLICE_W-1:0] i_cur,
  input  logic signed [SLICE_W-1:0] q_cur,
  input  logic signed [SLICE_W-1:0] i_prev,
  input  logic signed [SLICE_W-1:0] q_prev,
  output logic                      out_valid,
  output logic signed [DOT_W-1:0]   dot
);
  localparam int PW = 2 * SLICE_W;

  logic signed [SLICE_W-1:0] cur  [2];
  logic signed [SLICE_W-1:0] prev [2];
  logic signed [PW-1:0]      prod [2];
  logic                      mul_valid_reg;
  logic signed [DOT_W-1:0]   sum_next;

  assign cur[0]  = i_cur;
  assign cur[1]  = q_cur;
  assign prev[0] = i_prev;
  assign prev[1] = q_prev;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mul
      logic signed [PW-1:0] prod_reg;
      always_ff @(posedge clk) begin
        if (!rst) prod_reg <= '0;
        else if (in_valid) prod_reg <= cur[gi] * prev[gi];
      end
      assign prod[gi] = prod_reg;
    end
  endgenerate

  // One guard bit is enough: the only overflowing case is both products at +2^34.
  assign sum_next = $signed({prod[0][PW-1], prod[0]}) + $signed({prod[1][PW-1], prod[1]});

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mul_valid_reg <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      mul_valid_reg <= in_valid;
      out_valid     <= mul_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) dot <= '0;
    else if (mul_valid_reg && !flush) dot <= sum_next;
  end
endmodule

// File: rtl/dsss_dpsk_demod.sv
// DPSK demodulator: lock-qualified symbol capture, differential decision and byte assembly.
module dsss_dpsk_demod
  import dsss_dpsk_demod_pkg::*;
#(
  parameter int IW       = 23,
  parameter int MISS_MAX = MISS_MAX_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    bit_sync,
  input  logic signed [IW-1:0]    douti,
  input  logic signed [IW-1:0]    doutq,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  output logic signed [DOT_W-1:0] dot_out,
  output logic [1:0]              state
);
  localparam int MW = $clog2(MISS_MAX + 1);

  state_t                    state_reg, state_next;
  logic [MW-1:0]             miss_reg, miss_next;
  logic signed [SLICE_W-1:0] i_slice, q_slice;
  logic signed [SLICE_W-1:0] i_prev_reg, q_prev_reg;
  logic signed [SLICE_W-1:0] i_cap_reg, q_cap_reg, i_pcap_reg, q_pcap_reg;
  logic                      cap_valid_reg;
  logic                      prev_load, sym_accept, flush;
  logic [2:0]                bit_cnt_reg;
  logic [6:0]                shift_reg;
  logic [7:0]                byte_hold_reg, byte_asm;

  assign i_slice = douti[IW-1 -: SLICE_W];
  assign q_slice = doutq[IW-1 -: SLICE_W];

  always_comb begin
    state_next = state_reg;
    miss_next  = miss_reg;
    prev_load  = 1'b0;
    sym_accept = 1'b0;
    case (state_reg)
      ST_UNLOCK: if (locked) state_next = ST_FIRST;
      ST_FIRST: begin
        if (!locked) state_next = ST_UNLOCK;
        else if (bit_sync) begin
          prev_load  = 1'b1;
          state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (bit_sync && locked) begin
          sym_accept = 1'b1;
          prev_load  = 1'b1;
          miss_next  = '0;
        end else if (bit_sync) begin
          if (miss_reg >= MW'(MISS_MAX - 1)) state_next = ST_UNLOCK;
          else miss_next = miss_reg + MW'(1);
        end
      end
      default: state_next = ST_UNLOCK;
    endcase
    if (state_next == ST_UNLOCK) miss_next = '0;
    flush = (state_next == ST_UNLOCK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_UNLOCK;
      miss_reg      <= '0;
      i_prev_reg    <= '0;
      q_prev_reg    <= '0;
      i_cap_reg     <= '0;
      q_cap_reg     <= '0;
      i_pcap_reg    <= '0;
      q_pcap_reg    <= '0;
      cap_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      miss_reg      <= miss_next;
      cap_valid_reg <= sym_accept && !flush;
      if (sym_accept) begin
        i_cap_reg  <= i_slice;
        q_cap_reg  <= q_slice;
        i_pcap_reg <= i_prev_reg;
        q_pcap_reg <= q_prev_reg;
      end
      if (prev_load) begin
        i_prev_reg <= i_slice;
        q_prev_reg <= q_slice;
      end
    end
  end

  dpsk_dot u_dot (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (cap_valid_reg),
    .i_cur    (i_cap_reg),
    .q_cur    (q_cap_reg),
    .i_prev   (i_pcap_reg),
    .q_prev   (q_pcap_reg),
    .out_valid(bit_valid),
    .dot      (dot_out)
  );

  // The decision is the sign of the held dot, so bit_out holds with it.
  assign bit_out    = dot_out[DOT_W-1];
  assign byte_asm   = {shift_reg, bit_out};
  assign byte_valid = bit_valid && (bit_cnt_reg == 3'd7);
  assign byte_out   = byte_valid ? byte_asm : byte_hold_reg;
  assign state      = state_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      byte_hold_reg <= '0;
    end else begin
      if (state_next == ST_UNLOCK) begin
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end else if (bit_valid) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        shift_reg   <= byte_asm[6:0];
      end
      if (byte_valid) byte_hold_reg <= byte_asm;
    end
  end
endmodule
